alu_mul_seq: RTL and testbench

Multi-cycle sequencer that computes a 32x32 unsigned multiply (low 32 bits) by driving the CPU's shared 3-bit-opcode ALU through shift-add steps. It uses only the ALU operations add (`3'b010`) and srl (`3'b101`, which returns `Bdat>>1`). The block sits beside the multi-cycle control unit and owns the ALU operand/opcode muxes only while `busy` is high. It lets the core support MUL without adding a dedicated multiplier.

---
 rtl/alu_mul_seq.sv | 143 ++++++++++++++
 tb/tb_alu_mul_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// alu_mul_seq
// Sequencer that computes the low 32 bits of an unsigned 32x32 multiply by
// borrowing the CPU's shared ALU for shift-add steps (add = 3'b010,
// srl = 3'b101 returning Bdat>>1).
//
// Ports:
//   clk, rst             - rising-edge clock, synchronous active-high reset
//   start, a, b          - start request and operands (captured in IDLE)
//   alu_result, alu_zero - combinational result/zero flag of the shared ALU
//   alu_a, alu_b, alu_op - ALU operand/opcode requests (valid while busy)
//   busy                 - sequencer owns the ALU (ACC/DBL/SHR)
//   done                 - one-cycle pulse, product valid
//   product              - registered result, held until next start/reset
//
// Build option: define MUL_EARLY_EXIT_EN to leave the loop as soon as the
// shifted multiplier becomes zero (latency tracks the bit length of b).
module alu_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_DBL,
    S_SHR,
    S_DONE
  } state_e;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_NOP = 3'b000;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] product_q, product_d;
  logic        exit_early;

`ifdef MUL_EARLY_EXIT_EN
  // In SHR the ALU result is the shifted multiplier; zero means no set bits
  // remain, so further iterations cannot change acc.
  assign exit_early = alu_zero;
`else
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;
  assign exit_early      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    alu_op    = OP_NOP;
    alu_a     = '0;
    alu_b     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = a;
          mplier_d = b;
          cnt_d    = '0;
          state_d  = b[0] ? S_ACC : S_DBL;
        end
      end
      S_ACC: begin
        alu_op  = OP_ADD;
        alu_a   = acc_q;
        alu_b   = mcand_q;
        acc_d   = alu_result;
        state_d = S_DBL;
      end
      S_DBL: begin
        alu_op  = OP_ADD;
        alu_a   = mcand_q;
        alu_b   = mcand_q;
        mcand_d = alu_result;
        state_d = S_SHR;
      end
      S_SHR: begin
        alu_op   = OP_SRL;
        alu_a    = '0;
        alu_b    = mplier_q;
        mplier_d = alu_result;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31 || exit_early) begin
          // acc is final here; loading product on entry to DONE makes it
          // valid in the same cycle done pulses.
          product_d = acc_q;
          state_d   = S_DONE;
        end else begin
          state_d = alu_result[0] ? S_ACC : S_DBL;
        end
      end
      S_DONE: begin
        product_d = acc_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == S_ACC) || (state_q == S_DBL) || (state_q == S_SHR);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq
// Scoreboard bench for alu_mul_seq. A behavioural model of the shared ALU
// (add / srl) closes the loop; expected product and done latency are queued
// when a start is issued and compared when done pulses.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a_i, b_i;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        busy, done;
  logic [31:0] product;

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a_i),
    .b          (b_i),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .busy       (busy),
    .done       (done),
    .product    (product)
  );

  // Shared ALU model
  always_comb begin
    case (alu_op)
      3'b010:  alu_result = alu_a + alu_b;
      3'b101:  alu_result = alu_b >> 1;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] prod;
    int unsigned lat;
    int unsigned t0;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned last_t0;
  int          n_checks = 0;
  int          n_fail   = 0;

`ifdef MUL_EARLY_EXIT_EN
  localparam int unsigned LAT_3X5 = 9;
  localparam int unsigned LAT_B0  = 3;
`else
  localparam int unsigned LAT_3X5 = 67;
  localparam int unsigned LAT_B0  = 65;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected start-to-done latency: 2 cycles per iteration, +1 per set bit
  // processed, +1 for the DONE cycle.
  function automatic int unsigned exp_lat(input logic [31:0] bv);
    int unsigned pc = 0;
    int unsigned n  = 32;
    for (int i = 0; i < 32; i++) pc += bv[i];
`ifdef MUL_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < 32; i++) if (bv[i]) n = i + 1;
`endif
    return 2 * n + pc + 1;
  endfunction

  // Drive a start in the next cycle and queue its expectation; operands are
  // scrambled right after acceptance.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input int unsigned lat);
    exp_t e;
    @(negedge clk);
    a_i   = av;
    b_i   = bv;
    start = 1'b1;
    e.prod  = av * bv;
    e.lat   = lat;
    e.t0    = cyc;
    last_t0 = cyc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a_i   = $urandom;
    b_i   = $urandom;
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (sb_q.size() != 0) begin
      check_val("timeout_pending", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  // Result monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("product", product, mon_e.prod);
        check_val("latency", cyc - mon_e.t0, mon_e.lat);
      end
    end
  end

  logic [2:0]  tr_op [5];
  logic [31:0] tr_a  [5];
  logic [31:0] tr_b  [5];

  initial begin
    logic [31:0] ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy",    {31'd0, busy}, 32'd0);
    check_val("rst_done",    {31'd0, done}, 32'd0);
    check_val("rst_product", product, 32'd0);
    check_val("rst_alu_op",  {29'd0, alu_op}, 32'd0);
    check_val("rst_alu_a",   alu_a, 32'd0);
    check_val("rst_alu_b",   alu_b, 32'd0);
    rst = 1'b0;

    issue(32'd3, 32'd5, LAT_3X5);
    wait_drain(200);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 97);
    wait_drain(200);
    // Back-to-back: issue lands in the cycle right after done
    issue(32'h1234_5678, 32'd0, LAT_B0);
    wait_drain(200);

    // ALU operand/opcode trace for 7*2
    tr_op[0] = 3'b010; tr_a[0] = 32'd7;  tr_b[0] = 32'd7;
    tr_op[1] = 3'b101; tr_a[1] = 32'd0;  tr_b[1] = 32'd2;
    tr_op[2] = 3'b010; tr_a[2] = 32'd0;  tr_b[2] = 32'd14;
    tr_op[3] = 3'b010; tr_a[3] = 32'd14; tr_b[3] = 32'd14;
    tr_op[4] = 3'b101; tr_a[4] = 32'd0;  tr_b[4] = 32'd1;
    issue(32'd7, 32'd2, exp_lat(32'd2));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val($sformatf("trace%0d_op", i), {29'd0, alu_op}, {29'd0, tr_op[i]});
      check_val($sformatf("trace%0d_a", i), alu_a, tr_a[i]);
      check_val($sformatf("trace%0d_b", i), alu_b, tr_b[i]);
      check_val($sformatf("trace%0d_busy", i), {31'd0, busy}, 32'd1);
    end
    wait_drain(200);

    // Start while busy is ignored
    issue(32'd100, 32'd9, exp_lat(32'd9));
    while (cyc < last_t0 + 10) @(negedge clk);
    a_i   = 32'd5;
    b_i   = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain(200);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("hold_product", product, 32'd900);
      check_val("hold_busy", {31'd0, busy}, 32'd0);
    end

    // Reset mid-operation aborts without a done pulse
    issue(32'hDEAD_BEEF, 32'h0000_F00F, exp_lat(32'h0000_F00F));
    while (cyc < last_t0 + 20) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("abort_busy",    {31'd0, busy}, 32'd0);
    check_val("abort_done",    {31'd0, done}, 32'd0);
    check_val("abort_product", product, 32'd0);
    check_val("abort_alu_op",  {29'd0, alu_op}, 32'd0);
    repeat (120) @(negedge clk);
    issue(32'd6, 32'd7, exp_lat(32'd7));
    wait_drain(200);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      issue(ra, rb, exp_lat(rb));
      wait_drain(200);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
